// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// using a single full-adder slice (a + ~b + 1) with a carry flop and a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sr;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          a_msb;
    logic          b_msb;

    logic          accept;
    logic          last;
    logic          sum_bit;
    logic          carry_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Single full-adder slice: a + ~b + carry, carry seeded with 1
    always_comb begin
        sum_bit   = sa[0] ^ sb[0] ^ carry;
        carry_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    end

    // Serial datapath and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept) begin
                sa    <= a;
                sb    <= ~b;
                sr    <= '0;
                carry <= 1'b1;
                cnt   <= '0;
                a_msb <= a[N-1];
                b_msb <= b[N-1];
            end else if (state == RUN) begin
                sa    <= {1'b0, sa[N-1:1]};
                sb    <= {1'b0, sb[N-1:1]};
                sr    <= {sum_bit, sr[N-1:1]};
                carry <= carry_nxt;
                cnt   <= cnt + CW'(1);
            end
            // The last slice result goes straight to the outputs, so sum_bit is the result MSB
            if (last) begin
                diff <= {sum_bit, sr[N-1:1]};
                bout <= ~carry_nxt;
                ovf  <= (a_msb != b_msb) & (sum_bit != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at N=8 and N=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  diff8;
    logic        bout8;
    logic        ovf8;
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] diff16;
    logic        bout16;
    logic        ovf16;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  prev8    = 8'd0;

    serial_subtractor #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8),
        .ovf   (ovf8)
    );

    serial_subtractor #(.N(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .diff  (diff16),
        .bout  (bout16),
        .ovf   (ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; inputs are driven and outputs sampled on the falling edge
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input logic eo,
                       input bit issue, input bit poke, input bit chain,
                       input logic [7:0] na, input logic [7:0] nb);
        int c;
        int bc;
        bit hold_ok;
        if (issue) begin
            @(negedge clk);
            check({tag, "_idle_done"}, 32'(done8), 32'd0);
            start8 = 1'b1;
            a8     = av;
            b8     = bv;
            @(negedge clk);
            start8 = 1'b0;
            a8     = ~av;
            b8     = ~bv;
        end
        c       = 1;
        bc      = 0;
        hold_ok = 1'b1;
        while (!done8 && c < 20) begin
            if (busy8) bc++;
            if (diff8 !== prev8) hold_ok = 1'b0;
            if (poke && c == 3) begin
                start8 = 1'b1;
                a8     = 8'd1;
                b8     = 8'd2;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 32'(c), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_diff_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
        check({tag, "_diff"}, 32'(diff8), 32'(ed));
        check({tag, "_bout"}, 32'(bout8), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
        prev8 = ed;
        if (chain) begin
            start8 = 1'b1;
            a8     = na;
            b8     = nb;
            @(negedge clk);
            start8 = 1'b0;
            a8     = 8'h00;
            b8     = 8'h00;
            check({tag, "_b2b_busy"}, 32'(busy8), 32'd1);
            check({tag, "_b2b_done_low"}, 32'(done8), 32'd0);
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input logic eo);
        int c;
        int bc;
        @(negedge clk);
        start16 = 1'b1;
        a16     = av;
        b16     = bv;
        @(negedge clk);
        start16 = 1'b0;
        a16     = 16'h5A5A;
        b16     = 16'hA5A5;
        c  = 1;
        bc = 0;
        while (!done16 && c < 40) begin
            if (busy16) bc++;
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, 32'(c), 32'd17);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd16);
        check({tag, "_diff"}, 32'(diff16), 32'(ed));
        check({tag, "_bout"}, 32'(bout16), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf16), 32'(eo));
    endtask

    initial begin
        bit seen_done;
        rst     = 1'b1;
        start8  = 1'b0;
        a8      = 8'h00;
        b8      = 8'h00;
        start16 = 1'b0;
        a16     = 16'h0000;
        b16     = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_diff16", 32'(diff16), 32'd0);

        op8("t200_55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        op8("t10_20", 8'd10, 8'd20, 8'hF6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        op8("t0_0", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        op8("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        op8("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        op8("tff_7f", 8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        // Start during RUN is ignored; start held in the done cycle chains a second operation
        op8("poke", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd10, 8'd20);
        op8("chain", 8'd10, 8'd20, 8'hF6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Reset in the fourth RUN cycle, together with start: aborts with no done
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'd200;
        b8     = 8'd55;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start8 = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_bout", 32'(bout8), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) seen_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        prev8 = 8'd0;
        op8("after_rst", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        op16("w1000_3000", 16'd1000, 16'd3000, 16'hF830, 1'b1, 1'b0);
        op16("w8000_0001", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        op16("w1234_1234", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
        op16("w7fff_8000", 16'h7FFF, 16'h8000, 16'hFFFF, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes A − B one bit per clock, LSB first. A single full-adder datapath forms a + ~b + carry, and the carry is held in a flop between cycles. The block is the subtract counterpart of the team's gate-level adder cells and serves area-constrained datapaths that can trade latency for logic. A start/busy/done handshake lets a controller issue operands and collect the difference, the borrow and the signed-overflow flags.

## Interface
- N, default 8: operand and result width in bits; legal range N ≥ 2.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request to begin; sampled only when busy = 0.
- a  input  N  minuend; captured on the cycle start is accepted.
- b  input  N  subtrahend; captured on the cycle start is accepted.
- busy  output  1  high while serial bits are being processed.
- done  output  1  one-cycle pulse when diff, bout and ovf are updated.
- diff  output  N  registered result, (a − b) mod 2^N.
- bout  output  1  borrow out; 1 iff a < b as unsigned numbers.
- ovf  output  1  signed overflow of a − b.

## Operation
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1.
  - DONE: done = 1, busy = 0.
- Accepting start:
  - start is accepted in IDLE or DONE.
  - On acceptance: load a into shift register SA and ~b into SB. Clear the result shift register SR. Set carry to 1. Clear the bit counter. Enter RUN.
- Each RUN cycle:
  - s = SA[0] ^ SB[0] ^ carry.
  - carry ← majority(SA[0], SB[0], carry).
  - SA and SB shift right by one.
  - SR shifts right, with s inserted at SR[N−1].
  - The counter increments.
- Leaving RUN:
  - After the N-th RUN cycle, move to DONE.
  - On that transition, diff ← final SR, bout ← ~carry.
  - ovf ← (a[N−1] ≠ b[N−1]) & (result[N−1] ≠ a[N−1]), using the captured operand MSBs.
- Leaving DONE:
  - Go to IDLE, unless start is high, in which case go to RUN with new operands (back-to-back issue).
- Ignored input: start while busy = 1 has no effect.
- Operand capture: a and b are don't-care except in the accept cycle. Later changes to a or b do not affect an operation in progress.
- Output hold: diff, bout and ovf change only on the RUN→DONE transition or on reset. They hold the previous result throughout IDLE and RUN.
- Reset: rst = 1 at a rising edge forces IDLE and sets busy = done = bout = ovf = 0 and diff = 0. A reset during RUN aborts the operation, and no done is produced.
- Counter: width is $clog2(N)+1 bits. Wrap-around of the counter must not occur within one operation.

## Timing
- Start accepted at edge T. busy is high during cycles T+1 … T+N, i.e. for exactly N cycles.
- The edge at the end of cycle T+N loads the outputs. done is high in cycle T+N+1, and diff, bout and ovf are valid from that cycle.
- Latency from start to done is N+1 cycles.
- With start held high continuously, a new operation begins every N+1 cycles. The next busy period begins in the cycle after done.
- If rst and start are high in the same cycle, rst wins.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- N=8, a=200, b=55 → after 9 cycles, done pulses with diff=145, bout=0, ovf=0; busy is high for exactly 8 cycles.
- N=8, a=10, b=20 → diff=246 (0xF6), bout=1, ovf=0. a=0, b=0 → diff=0, bout=0, ovf=0.
- N=8, a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Start during RUN with different operands → ignored; the first result is 145 as in the first scenario. Start held high in the done cycle → a second operation starts, busy rises in the next cycle, and the second done arrives 9 cycles after the first.
- rst asserted at cycle 4 of RUN → busy=0 and diff=0 on the next cycle, and no done pulse follows. A fresh start then produces a correct result.
- Randomized sweep, N=8 and N=16, of 1000 operand pairs against a reference model: diff, bout and ovf all match. The diff output holds its old value during RUN.
